// File: rtl/jtframe_psram_pkg.sv
`default_nettype none
// ============================================================================
// jtframe_psram_pkg : encodings shared by the PSRAM emulator files
// Revision 1.0
// ============================================================================
package jtframe_psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LAT   = 3'd1,
    ST_CFG   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } st_e;

  localparam int          c_BCR_ASYNC    = 15;
  localparam int          c_BCR_LAT_LSB  = 11;
  localparam int          c_BCR_WAIT_POL = 10;
  localparam int          c_SEL_LSB      = 18;

  localparam logic [15:0] c_BCR_RST      = 16'h9D1F;
  localparam logic [15:0] c_RCR_RST      = 16'h0010;

  localparam logic [1:0]  c_SEL_RCR      = 2'd0;
  localparam logic [1:0]  c_SEL_DIDR     = 2'd1;
  localparam logic [1:0]  c_SEL_BCR      = 2'd2;

  // Latency codes 0 and 7 are reserved on the real part and behave as 3 here.
  function automatic logic [2:0] lat_cycles(input logic [15:0] bcr);
    logic [2:0] code;
    code = bcr[c_BCR_LAT_LSB +: 3];
    return (code == 3'd0 || code == 3'd7) ? 3'd3 : code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_psram_mem.sv
`default_nettype none
// ============================================================================
// jtframe_psram_mem : single-port 2^MW x16 BRAM, byte enables, registered read
// Revision 1.0
// ============================================================================
module jtframe_psram_mem #(
  parameter int MW = 14
) (
  input  logic          clk,
  input  logic [MW-1:0] addr,
  input  logic [15:0]   din,
  input  logic [1:0]    we,
  output logic [15:0]   dout
);

  logic [15:0] mem_q [2**MW];
  logic [15:0] dout_q;

  always_ff @(posedge clk) begin
    if (we[0]) mem_q[addr][7:0]  <= din[7:0];
    if (we[1]) mem_q[addr][15:8] <= din[15:8];
    dout_q <= mem_q[addr];
  end

  assign dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/jtframe_psram_emu.sv
`default_nettype none
// ============================================================================
// jtframe_psram_emu : BRAM-backed CellularRAM responder for the line frame buffer
// Revision 1.0
// ============================================================================
module jtframe_psram_emu
  import jtframe_psram_pkg::*;
#(
  parameter int          MW   = 14,
  parameter int          DIE  = 0,
  parameter logic [15:0] DIDR = 16'h0143
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [5:0]  cr_addr,
  inout  wire  [15:0] cr_adq,
  output logic        cr_wait,
  input  logic        cr_advn,
  input  logic        cr_cre,
  input  logic [1:0]  cr_cen,
  input  logic        cr_oen,
  input  logic        cr_wen,
  input  logic [1:0]  cr_dsn,
  output logic [15:0] bcr,
  output logic [15:0] rcr
);

  st_e           st_q,   st_d;
  logic [1:0]    sel_q,  sel_d;
  logic          cre_q,  cre_d;
  logic          wen_q,  wen_d;
  logic [2:0]    cnt_q,  cnt_d;
  logic [MW-1:0] ptr_q,  ptr_d;
  logic          wait_q, wait_d;
  logic [15:0]   bcr_q,  bcr_d;
  logic [15:0]   rcr_q,  rcr_d;

  logic          cen;
  logic [21:0]   cmd_addr;
  logic [1:0]    cmd_sel;
  logic [1:0]    mem_we;
  logic [15:0]   mem_rd;
  logic [15:0]   cfg_word;
  logic [15:0]   dout;
  logic          drive;
  logic          unused_bits;

  assign cen         = cr_cen[DIE];
  assign cmd_addr    = {cr_addr, cr_adq};
  assign cmd_sel     = cmd_addr[c_SEL_LSB +: 2];
  assign unused_bits = ^{cmd_addr, cr_cen};

  always_comb begin
    st_d   = st_q;
    sel_d  = sel_q;
    cre_d  = cre_q;
    wen_d  = wen_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    wait_d = wait_q;
    bcr_d  = bcr_q;
    rcr_d  = rcr_q;
    if (cen) begin
      st_d   = ST_IDLE;
      wait_d = 1'b0;
    end else if (!cr_advn) begin
      sel_d = cmd_sel;
      cre_d = cr_cre;
      wen_d = cr_wen;
      cnt_d = 3'd0;
      ptr_d = cmd_addr[MW-1:0];
      if (cr_cre && !cr_wen) begin
        if (cmd_sel == c_SEL_BCR)      bcr_d = cmd_addr[15:0];
        else if (cmd_sel == c_SEL_RCR) rcr_d = cmd_addr[15:0];
      end
      // Array traffic is not served in asynchronous mode.
      if (!cr_cre && bcr_q[c_BCR_ASYNC]) begin
        st_d   = ST_IDLE;
        wait_d = ~bcr_q[c_BCR_WAIT_POL];
      end else begin
        st_d   = ST_LAT;
        wait_d = ~bcr_d[c_BCR_WAIT_POL];
      end
    end else begin
      case (st_q)
        ST_LAT: begin
          if (cnt_q + 3'd1 == lat_cycles(bcr_q)) begin
            wait_d = bcr_q[c_BCR_WAIT_POL];
            if (wen_q)      st_d = ST_RDATA;
            else if (cre_q) st_d = ST_CFG;
            else            st_d = ST_WDATA;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        // ptr runs one word ahead of the bus because the RAM read is registered.
        ST_WDATA, ST_RDATA: begin
          if (!cre_q) ptr_d = ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      sel_q  <= 2'd0;
      cre_q  <= 1'b0;
      wen_q  <= 1'b0;
      cnt_q  <= 3'd0;
      ptr_q  <= '0;
      wait_q <= 1'b0;
      bcr_q  <= c_BCR_RST;
      rcr_q  <= c_RCR_RST;
    end else begin
      st_q   <= st_d;
      sel_q  <= sel_d;
      cre_q  <= cre_d;
      wen_q  <= wen_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      wait_q <= wait_d;
      bcr_q  <= bcr_d;
      rcr_q  <= rcr_d;
    end
  end

  assign mem_we = (st_q == ST_WDATA && !cen && cr_advn) ? ~cr_dsn : 2'b00;

  jtframe_psram_mem #(
    .MW   (MW)
  ) u_mem (
    .clk  (clk),
    .addr (ptr_q),
    .din  (cr_adq),
    .we   (mem_we),
    .dout (mem_rd)
  );

  always_comb begin
    cfg_word = 16'h0000;
    case (sel_q)
      c_SEL_BCR:  cfg_word = bcr_q;
      c_SEL_DIDR: cfg_word = DIDR;
      c_SEL_RCR:  cfg_word = rcr_q;
      default:    cfg_word = 16'h0000;
    endcase
  end

  assign dout    = cre_q ? cfg_word : mem_rd;
  assign drive   = (st_q == ST_RDATA) && !cen && !cr_oen;
  assign cr_adq  = drive ? dout : 16'hzzzz;
  assign cr_wait = wait_q;
  assign bcr     = bcr_q;
  assign rcr     = rcr_q;

endmodule
`default_nettype wire
